// File: rtl/req_buffer.sv
// req_buffer: buffers master transactions in a small FIFO and issues them one at a
// time onto an arbitrated bus. Each entry is requested from the arbiter, presented on
// the bus for a single cycle once granted, and retired when the slave acknowledges.
// The head entry stays in the FIFO until it completes, so count includes it.
//
// Optional feature: define REQ_BUFFER_TIMEOUT_EN to add an ack timeout. After 16
// WAIT_ACK cycles without bus_ack the head is retired with rsp_rdata all ones and
// err pulses for one cycle. Without the macro there is no err port and WAIT_ACK
// waits indefinitely.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   in_valid/in_ready        master handshake; in_we, in_addr, in_wdata are the payload
//   req, gnt                 arbiter request / grant
//   bus_valid                head transaction on the bus (one cycle per transfer)
//   bus_we/addr/wdata        head-entry fields while the transfer is in flight, else 0
//   bus_ack, bus_rdata       slave completion and read data
//   rsp_valid, rsp_rdata     one-cycle completion pulse and captured read data
//   count                    entries held, including the in-flight head
//   err                      (REQ_BUFFER_TIMEOUT_EN only) timeout completion pulse

module req_buffer #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_we,
   input  logic [ADDR_W-1:0]          in_addr,
   input  logic [DATA_W-1:0]          in_wdata,
   output logic                       req,
   input  logic                       gnt,
   output logic                       bus_valid,
   output logic                       bus_we,
   output logic [ADDR_W-1:0]          bus_addr,
   output logic [DATA_W-1:0]          bus_wdata,
   input  logic                       bus_ack,
   input  logic [DATA_W-1:0]          bus_rdata,
   output logic                       rsp_valid,
   output logic [DATA_W-1:0]          rsp_rdata,
`ifdef REQ_BUFFER_TIMEOUT_EN
   output logic                       err,
`endif
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StXfer,
      StWaitAck
   } state_e;

   state_e state_q, state_d;

   // Entry storage; data arrays need no reset since count gates their use.
   logic              mem_we    [DEPTH];
   logic [ADDR_W-1:0] mem_addr  [DEPTH];
   logic [DATA_W-1:0] mem_wdata [DEPTH];

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;

   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;

   logic push, pop;
   logic complete;
   logic timeout;
   logic in_flight;

   logic              head_we;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_wdata;

`ifdef REQ_BUFFER_TIMEOUT_EN
   logic [3:0] tmo_cnt_q, tmo_cnt_d;
   logic       err_q;
`endif

   // Registered count only, so a pop in the same cycle never frees a slot early.
   assign in_ready = (count_q < CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = complete;
   assign count    = count_q;

   assign head_we    = mem_we[rd_ptr_q];
   assign head_addr  = mem_addr[rd_ptr_q];
   assign head_wdata = mem_wdata[rd_ptr_q];

   assign in_flight = (state_q == StXfer) || (state_q == StWaitAck);
   assign bus_we    = in_flight ? head_we    : 1'b0;
   assign bus_addr  = in_flight ? head_addr  : '0;
   assign bus_wdata = in_flight ? head_wdata : '0;

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;

   // FSM next state and outputs.
   always_comb begin
      state_d   = state_q;
      req       = 1'b0;
      bus_valid = 1'b0;
      complete  = 1'b0;
      timeout   = 1'b0;
`ifdef REQ_BUFFER_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) state_d = StReq;
         end
         StReq: begin
            req = 1'b1;
            if (gnt) state_d = StXfer;
         end
         StXfer: begin
            req       = 1'b1;
            bus_valid = 1'b1;
            if (bus_ack) begin
               complete = 1'b1;
            end else begin
               state_d = StWaitAck;
`ifdef REQ_BUFFER_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end
         end
         StWaitAck: begin
            req = 1'b1;
            if (bus_ack) begin
               complete = 1'b1;
            end else begin
`ifdef REQ_BUFFER_TIMEOUT_EN
               // The 16th silent WAIT_ACK cycle retires the head.
               if (tmo_cnt_q == 4'hF) begin
                  complete = 1'b1;
                  timeout  = 1'b1;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 4'd1;
               end
`endif
            end
         end
         default: state_d = StIdle;
      endcase

      // Decision uses count before any same-cycle push; IDLE picks up late pushes.
      if (complete) state_d = (count_q > CW'(1)) ? StReq : StIdle;
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rsp_valid_q <= complete;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         if (complete) begin
            if (timeout)      rsp_rdata_q <= '1;
            else if (head_we) rsp_rdata_q <= '0;
            else              rsp_rdata_q <= bus_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_we[wr_ptr_q]    <= in_we;
         mem_addr[wr_ptr_q]  <= in_addr;
         mem_wdata[wr_ptr_q] <= in_wdata;
      end
   end

`ifdef REQ_BUFFER_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= timeout;
      end
   end

   assign err = err_q;
`else
   // Timeout path absent; keep the signal tied so the completion mux stays uniform.
   logic unused_timeout;
   assign unused_timeout = timeout;
`endif

endmodule

// File: doc/req_buffer.md
REQ_BUFFER -- requirements
Module: req_buffer

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO entries; power of two, 2..16.
REQ-002 Parameter ADDR_W, default 8, bus address width.
REQ-003 Parameter DATA_W, default 8, bus data width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  master offers a transaction.
REQ-007 in_ready  output  1  buffer accepts; transfer when in_valid&&in_ready.
REQ-008 in_we  input  1  1=write, 0=read.
REQ-009 in_addr  input  ADDR_W  transaction address.
REQ-010 in_wdata  input  DATA_W  write data (ignored for reads).
REQ-011 req  output  1  bus request to arbiter.
REQ-012 gnt  input  1  arbiter grant.
REQ-013 bus_valid  output  1  transaction on bus toward slave.
REQ-014 bus_we, bus_addr, bus_wdata  output  1/ADDR_W/DATA_W  head-entry fields.
REQ-015 bus_ack  input  1  slave completion.
REQ-016 bus_rdata  input  DATA_W  slave read data, valid with bus_ack.
REQ-017 rsp_valid  output  1  one-cycle pulse per completed transaction.
REQ-018 rsp_rdata  output  DATA_W  captured bus_rdata (read) or 0 (write).
REQ-019 count  output  $clog2(DEPTH)+1  entries held, including in-flight head.

Function
REQ-020 FIFO stores {we,addr,wdata}; in_ready = (count<DEPTH); push on in_valid&&in_ready.
REQ-021 Head entry is popped only on completion (ack or timeout), never on grant.
REQ-022 FSM states IDLE, REQ, XFER, WAIT_ACK.
REQ-023 IDLE: req=0; if count>0 next REQ.
REQ-024 REQ: req=1; on gnt=1 next XFER; req held until grant.
REQ-025 XFER: req=1, bus_valid=1 with head fields for exactly one cycle; if bus_ack=1 in this cycle complete immediately, else next WAIT_ACK.
REQ-026 WAIT_ACK: req=1, bus_valid=0, bus fields held stable; on bus_ack complete.
REQ-027 Completion: pop head, rsp_valid=1 next cycle, rsp_rdata=bus_rdata if read else 0; next REQ if count-1>0 else IDLE.
REQ-028 Minimum latency push->rsp_valid with gnt tied high and same-cycle ack: 4 cycles.
REQ-029 Simultaneous push and pop: count unchanged; push allowed even when count==DEPTH in that cycle is NOT permitted (in_ready uses registered count).
REQ-030 Pointers wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-031 bus_ack outside XFER/WAIT_ACK ignored; gnt outside REQ ignored.

Reset
REQ-032 rst=1 at a clock edge: state IDLE, pointers/count 0, req=0, bus_valid=0, bus_we/addr/wdata=0, rsp_valid=0, rsp_rdata=0, in_ready=1 next cycle.
REQ-033 Reset mid-transaction discards all entries, including in-flight head; no rsp_valid issued for it.

Configuration
REQ-034 Macro REQ_BUFFER_TIMEOUT_EN defined: 4-bit counter runs in WAIT_ACK; 16 cycles without bus_ack -> head popped, rsp_valid=1 with rsp_rdata=all ones, output err pulses 1 cycle.
REQ-035 Macro undefined: no counter, no err port; WAIT_ACK waits indefinitely.

Verification
REQ-036 Reset: rst high 2 cycles -> req=0, bus_valid=0, count=0, in_ready=1.
REQ-037 Single write addr=0x12 data=0xA5, gnt=1, ack in XFER -> bus_valid one cycle with 0x12/0xA5, rsp_valid 4 cycles after push, rsp_rdata=0.
REQ-038 Fill: 5 pushes with DEPTH=4, gnt=0 -> in_ready=0 after 4th, count=4, 5th held until first completion.
REQ-039 Read, gnt delayed 3 cycles, ack 2 cycles after XFER with rdata=0x3C -> req held throughout, rsp_rdata=0x3C, order preserved for 3 queued reads.
REQ-040 rst asserted in WAIT_ACK with 2 entries -> count=0, no rsp_valid, later ack ignored.
REQ-041 With REQ_BUFFER_TIMEOUT_EN, no ack -> after 16 WAIT_ACK cycles err=1, rsp_rdata=0xFF, next entry requested.
